// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply controller.
// Optional debug tap on PE(0,0) is built only when SYSTOLIC_DEBUG_EN is defined.
package systolic_pkg;

    localparam int W_DEF = 16;
    localparam int N_DEF = 3;
    localparam int CNT_W_DEF = $clog2(3 * N_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int n);
        return $clog2(3 * n);
    endfunction

    // Bit offset of element (r,c) in a packed row-major matrix.
    function automatic int elem_idx(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/systolic_if.sv
// Host-side bundle: start/mode/operands in, packed result, done pulse and debug tap out.
interface systolic_if
    import systolic_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
);
    logic               i_en;
    logic               i_mode;
    logic [W*N*N-1:0]   i_A;
    logic [W*N*N-1:0]   i_B;
    logic [W*N*N-1:0]   o_C;
    logic               o_done;
    logic [W-1:0]       o_d_a00;

    modport master (
        output i_en, i_mode, i_A, i_B,
        input  o_C, o_done, o_d_a00
    );

    modport slave (
        input  i_en, i_mode, i_A, i_B,
        output o_C, o_done, o_d_a00
    );
endinterface

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: accumulates a*b and forwards operands east/south.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic [W-1:0] acc
);
    // Product truncated to W bits before accumulation; the sum wraps at W bits.
    logic [W-1:0] prod;
    assign prod = a_in * b_in;

    // Forwarding registers run every cycle so zeros fed outside RUN flush the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            if (clr)
                acc <= '0;
            else if (en)
                acc <= acc + prod;
        end
    end

endmodule

// File: rtl/systolic_control.sv
// NxN output-stationary systolic matrix multiply: FSM, operand skew, PE array, result register.
// Define SYSTOLIC_DEBUG_EN to drive o_d_a00 with the west input of PE(0,0); otherwise it is tied to 0.
module systolic_control
    import systolic_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    systolic_if.slave   bus
);
    localparam int CW   = cnt_width(N);
    localparam int LAST = 3 * N - 3;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic               start, clr, run;
    logic [W*N*N-1:0]   a_q, b_q, c_q, acc_flat;
    logic               done_q;

    logic [W-1:0]       a_west  [N];
    logic [W-1:0]       b_north [N];
    logic [W-1:0]       a_h     [N][N];
    logic [W-1:0]       b_v     [N][N];
    logic [W-1:0]       acc     [N][N];
    logic [W-1:0]       east_unused  [N];
    logic [W-1:0]       south_unused [N];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        clr      = 1'b0;
        run      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_en) begin
                    state_nx = LOAD;
                    start    = 1'b1;
                    clr      = bus.i_mode;
                end
            end
            LOAD: state_nx = RUN;
            RUN: begin
                run = 1'b1;
                if (cnt == CW'(LAST))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            cnt <= '0;
        else if (run)
            cnt <= cnt + 1'b1;
        else
            cnt <= '0;
    end

    // Operands are frozen at the start edge; later input changes cannot reach the array.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (start) begin
            a_q <= bus.i_A;
            b_q <= bus.i_B;
        end
    end

    // Skew: row r of A and column c of B enter delayed by r (resp. c) cycles.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_west[i]  = '0;
            b_north[i] = '0;
        end
        if (run) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (cnt == CW'(i + k)) begin
                        a_west[i]  = a_q[elem_idx(i, k, N, W) +: W];
                        b_north[i] = b_q[elem_idx(k, i, N, W) +: W];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            logic [W-1:0] a_i, b_i, a_o, b_o;

            if (c == 0) begin : g_west
                assign a_i = a_west[r];
            end else begin : g_east
                assign a_i = a_h[r][c-1];
            end

            if (r == 0) begin : g_north
                assign b_i = b_north[c];
            end else begin : g_south
                assign b_i = b_v[r-1][c];
            end

            systolic_pe #(.W(W)) u_pe (
                .clk   (i_clk),
                .rst_n (i_rst),
                .clr   (clr),
                .en    (run),
                .a_in  (a_i),
                .b_in  (b_i),
                .a_out (a_o),
                .b_out (b_o),
                .acc   (acc[r][c])
            );

            // Edge PEs have no downstream neighbour; their forwarded values are dropped.
            if (c < N - 1) begin : g_fwd_a
                assign a_h[r][c] = a_o;
            end else begin : g_end_a
                assign a_h[r][c]      = '0;
                assign east_unused[r] = a_o;
            end

            if (r < N - 1) begin : g_fwd_b
                assign b_v[r][c] = b_o;
            end else begin : g_end_b
                assign b_v[r][c]       = '0;
                assign south_unused[c] = b_o;
            end
        end
    end

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                acc_flat[elem_idx(i, j, N, W) +: W] = acc[i][j];
    end

    // Result is taken during the DONE cycle so o_done lands 3N edges after the start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            c_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if (state == DONE)
                c_q <= acc_flat;
        end
    end

    assign bus.o_C    = c_q;
    assign bus.o_done = done_q;

`ifdef SYSTOLIC_DEBUG_EN
    assign bus.o_d_a00 = a_west[0];
`else
    assign bus.o_d_a00 = '0;
`endif

endmodule

// File: tb/tb_systolic_control.sv
// Directed and randomized checks of systolic_control against a plain matrix-arithmetic model.
module tb_systolic_control;
    localparam int W  = 16;
    localparam int N  = 3;
    localparam int NN = N * N;
    localparam int VW = W * NN;

    typedef logic [VW-1:0] mat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_if #(.W(W), .N(N)) bus ();

    systolic_control #(.W(W), .N(N)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    mat_t c_model     = '0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] el(input mat_t m, input int r, input int c);
        return m[(r * N + c) * W +: W];
    endfunction

    function automatic mat_t mk9(input int e0, input int e1, input int e2, input int e3,
                                 input int e4, input int e5, input int e6, input int e7,
                                 input int e8);
        return {16'(e8), 16'(e7), 16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    function automatic mat_t rnd_mat();
        mat_t m;
        for (int i = 0; i < NN; i++)
            m[i * W +: W] = 16'($urandom);
        return m;
    endfunction

    // C = (clear ? 0 : Cprev) + A*B, each product and sum reduced mod 2^16.
    function automatic mat_t matmul(input mat_t a, input mat_t b, input mat_t cp, input logic clear);
        mat_t   res;
        longint s;
        res = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s = clear ? 0 : longint'(el(cp, r, c));
                for (int k = 0; k < N; k++)
                    s = (s + ((longint'(el(a, r, k)) * longint'(el(b, k, c))) % 65536)) % 65536;
                res[(r * N + c) * W +: W] = 16'(s);
            end
        return res;
    endfunction

    task automatic do_run(input mat_t a, input mat_t b, input logic mode, input string tag);
        int          n;
        logic [W-1:0] dexp;
        @(negedge clk);
        bus.i_en   = 1'b1;
        bus.i_A    = a;
        bus.i_B    = b;
        bus.i_mode = mode;
        @(posedge clk);
        #1;
        bus.i_en   = 1'b0;
        bus.i_A    = rnd_mat();
        bus.i_B    = rnd_mat();
        bus.i_mode = ~mode;
        c_model = matmul(a, b, c_model, mode);
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n <= 3 * N - 2) begin
`ifdef SYSTOLIC_DEBUG_EN
                dexp = (n - 1 < N) ? el(a, 0, n - 1) : '0;
`else
                dexp = '0;
`endif
                chk({tag, "_dbg"}, VW'(bus.o_d_a00), VW'(dexp));
            end
            if (bus.o_done) break;
        end
        chk({tag, "_latency"}, VW'(n), VW'(3 * N));
        chk({tag, "_C"}, bus.o_C, c_model);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, VW'(bus.o_done), VW'(0));
    endtask

    initial begin
        mat_t a, b, exp_c;
        int   dcount;

        bus.i_en   = 1'b0;
        bus.i_mode = 1'b0;
        bus.i_A    = '0;
        bus.i_B    = '0;

        // Reset values, and quiet while i_en stays low.
        #2;
        chk("rst_C", bus.o_C, '0);
        chk("rst_done", VW'(bus.o_done), '0);
        chk("rst_dbg", VW'(bus.o_d_a00), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("idle_done", VW'(bus.o_done), '0);
            chk("idle_C", bus.o_C, '0);
        end

        // Identity.
        a = mk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        do_run(a, mk9(1, 0, 0, 0, 1, 0, 0, 0, 1), 1'b1, "ident");
        chk("ident_eqA", bus.o_C, a);

        // General product.
        do_run(mk9(1, 2, 3, 4, 5, 6, 7, 8, 9), mk9(9, 8, 7, 6, 5, 4, 3, 2, 1), 1'b1, "gen");
        chk("gen_const", bus.o_C, mk9(30, 24, 18, 84, 69, 54, 138, 114, 90));

        // Wrap, then accumulate identity on top.
        a = mk9(16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00);
        do_run(a, a, 1'b1, "wrap");
        chk("wrap_const", bus.o_C, '0);
        do_run(mk9(1, 0, 0, 0, 1, 0, 0, 0, 1), mk9(1, 0, 0, 0, 1, 0, 0, 0, 1), 1'b0, "accum");
        chk("accum_const", bus.o_C, mk9(1, 0, 0, 0, 1, 0, 0, 0, 1));

        // Randomized runs, mixed clear/accumulate.
        for (int i = 0; i < 6; i++)
            do_run(rnd_mat(), rnd_mat(), 1'($urandom_range(0, 1)), "rand");

        // Back-to-back with mid-run input noise.
        a = rnd_mat();
        b = rnd_mat();
        exp_c  = matmul(a, b, '0, 1'b1);
        dcount = 0;
        @(negedge clk);
        bus.i_en   = 1'b1;
        bus.i_A    = a;
        bus.i_B    = b;
        bus.i_mode = 1'b1;
        for (int e = 0; e <= 24; e++) begin
            @(posedge clk);
            #1;
            if ((e >= 2 && e <= 7) || (e >= 12 && e <= 17)) begin
                bus.i_A    = rnd_mat();
                bus.i_B    = rnd_mat();
                bus.i_mode = 1'($urandom_range(0, 1));
            end else begin
                bus.i_A    = a;
                bus.i_B    = b;
                bus.i_mode = 1'b1;
            end
            if (e == 15) bus.i_en = 1'b0;
            if (bus.o_done) begin
                dcount++;
                chk("b2b_C", bus.o_C, exp_c);
                chk("b2b_time", VW'(e), VW'(dcount == 1 ? 9 : 19));
            end
        end
        chk("b2b_count", VW'(dcount), VW'(2));
        c_model = exp_c;

        // Abort mid-run.
        a = rnd_mat();
        b = rnd_mat();
        @(negedge clk);
        bus.i_en   = 1'b1;
        bus.i_A    = a;
        bus.i_B    = b;
        bus.i_mode = 1'b1;
        @(posedge clk);
        #1;
        bus.i_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_C", bus.o_C, '0);
        chk("abort_dbg", VW'(bus.o_d_a00), '0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_done", VW'(bus.o_done), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        c_model = '0;
        do_run(a, b, 1'b0, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
